// File: rtl/gige_mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO management controller.
// The boot-time init table is only consumed when GIGE_MDIO_INIT_EN is defined.
package gige_mdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_CMD,
    ST_TA,
    ST_DATA,
    ST_DONE
  } mdio_state_e;

  localparam logic [1:0] MDIO_ST = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] TA_WR   = 2'b10;
  localparam logic [1:0] TA_RD   = 2'b11;

  // Bit indices within the 64-bit frame (0 = first preamble bit)
  localparam logic [5:0] PRE_LAST  = 6'd31;
  localparam logic [5:0] CMD_LAST  = 6'd45;
  localparam logic [5:0] TA_LAST   = 6'd47;
  localparam logic [5:0] DATA_LAST = 6'd63;

  localparam int INIT_LEN = 4;

  typedef struct packed {
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] data;
  } mdio_wr_t;

  function automatic mdio_wr_t init_entry(input logic [1:0] idx);
    mdio_wr_t e;
    case (idx)
      2'd0:    e = '{phy: 5'd0, regad: 5'h09, data: 16'h0200};
      2'd1:    e = '{phy: 5'd1, regad: 5'h09, data: 16'h0200};
      2'd2:    e = '{phy: 5'd0, regad: 5'h00, data: 16'h1340};
      default: e = '{phy: 5'd1, regad: 5'h00, data: 16'h1340};
    endcase
    return e;
  endfunction

  // Whole frame, MSB sent first; read TA/data are don't-care (line released)
  function automatic logic [63:0] build_frame(input logic wr, input logic [4:0] phy,
                                              input logic [4:0] regad, input logic [15:0] data);
    return {32'hFFFF_FFFF, MDIO_ST, (wr ? OP_WR : OP_RD), phy, regad,
            (wr ? TA_WR : TA_RD), (wr ? data : 16'hFFFF)};
  endfunction

endpackage

// File: rtl/gige_mdio_tick.sv
// MDC generator: bit period of 2*MDC_DIV cycles, mdc low then high.
// bit_last marks the final cycle of a bit (registered outputs change next cycle); mdc_rise marks the sample cycle.
module gige_mdio_tick #(
  parameter int MDC_DIV = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic bit_last,
  output logic mdc_rise
);

  localparam int CW = (2 * MDC_DIV > 2) ? $clog2(2 * MDC_DIV) : 1;
  localparam logic [CW-1:0] HALF = CW'(MDC_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * MDC_DIV - 1);

  logic [CW-1:0] cnt, cnt_nxt;

  assign cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      mdc <= (cnt_nxt >= HALF);
    end
  end

  assign bit_last = en && (cnt == LAST);
  assign mdc_rise = en && (cnt == HALF);

endmodule

// File: rtl/gige_mdio_ctrl.sv
// Clause-22 MDIO master: one request at a time, 64-bit frames, single response strobe.
// Define GIGE_MDIO_INIT_EN to replay the package init table through the frame engine after reset.
module gige_mdio_ctrl
  import gige_mdio_pkg::*;
#(
  parameter int MDC_DIV = 13
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  output logic        init_done
);

  mdio_state_e state, state_nxt;
  logic [5:0]  bit_cnt;
  logic [63:0] sh, frame;
  logic        lat_write, is_init, ta_err;
  logic [15:0] rd_sh, rd_nxt;
  logic        start, s_write;
  logic [4:0]  s_phy, s_reg;
  logic [15:0] s_data;
  logic        in_frame, bit_last, mdc_rise;

  assign in_frame  = (state == ST_PRE) || (state == ST_CMD) || (state == ST_TA) || (state == ST_DATA);
  assign req_ready = (state == ST_IDLE) && init_done;
  assign rsp_valid = (state == ST_DONE) && !is_init;

  gige_mdio_tick #(.MDC_DIV(MDC_DIV)) u_tick (
    .clk      (clk_50),
    .rst_n    (reset_n),
    .en       (in_frame),
    .mdc      (mdc),
    .bit_last (bit_last),
    .mdc_rise (mdc_rise)
  );

`ifdef GIGE_MDIO_INIT_EN
  logic [2:0] init_idx;
  mdio_wr_t   init_w;
  logic       init_go;

  assign init_w  = init_entry(init_idx[1:0]);
  assign init_go = (state == ST_IDLE) && !init_done && (init_idx < 3'(INIT_LEN));
  assign start   = init_go || (req_valid && req_ready);

  always_comb begin
    s_write = req_write;
    s_phy   = req_phy;
    s_reg   = req_reg;
    s_data  = req_wdata;
    if (init_go) begin
      s_write = 1'b1;
      s_phy   = init_w.phy;
      s_reg   = init_w.regad;
      s_data  = init_w.data;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      init_idx  <= '0;
      init_done <= 1'b0;
      is_init   <= 1'b0;
    end else begin
      if (init_go) init_idx <= init_idx + 3'd1;
      if ((state == ST_IDLE) && !init_done && (init_idx == 3'(INIT_LEN))) init_done <= 1'b1;
      if (start) is_init <= init_go;
    end
  end
`else
  assign start   = req_valid && req_ready;
  assign s_write = req_write;
  assign s_phy   = req_phy;
  assign s_reg   = req_reg;
  assign s_data  = req_wdata;
  assign is_init = 1'b0;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) init_done <= 1'b0;
    else          init_done <= 1'b1;
  end
`endif

  assign frame = build_frame(s_write, s_phy, s_reg, s_data);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_PRE;
      ST_PRE:  if (bit_last && bit_cnt == PRE_LAST)  state_nxt = ST_CMD;
      ST_CMD:  if (bit_last && bit_cnt == CMD_LAST)  state_nxt = ST_TA;
      ST_TA:   if (bit_last && bit_cnt == TA_LAST)   state_nxt = ST_DATA;
      ST_DATA: if (bit_last && bit_cnt == DATA_LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Last data bit may be sampled in the same cycle the frame ends when MDC_DIV is 1
  always_comb begin
    rd_nxt = rd_sh;
    if (mdc_rise && state == ST_DATA) rd_nxt = {rd_sh[14:0], mdio_i};
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      sh        <= '0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      lat_write <= 1'b0;
      rd_sh     <= '0;
      ta_err    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rd_sh <= rd_nxt;
      if (start) begin
        bit_cnt   <= '0;
        sh        <= {frame[62:0], 1'b0};
        mdio_o    <= frame[63];
        mdio_oe   <= 1'b1;
        lat_write <= s_write;
        ta_err    <= 1'b0;
      end else begin
        if (mdc_rise && state == ST_TA && bit_cnt == TA_LAST && !lat_write) ta_err <= mdio_i;
        if (bit_last) begin
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == DATA_LAST) begin
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b0;
            if (!is_init) begin
              rsp_rdata <= lat_write ? 16'h0000 : rd_nxt;
              rsp_err   <= !lat_write && ta_err;
            end
          end else begin
            mdio_o  <= sh[63];
            sh      <= {sh[62:0], 1'b0};
            // Reads hand the line to the PHY from the first TA bit onward
            mdio_oe <= lat_write || (bit_cnt < CMD_LAST);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gige_mdio_ctrl.sv
// Directed bench for gige_mdio_ctrl: frame capture on mdc rises, a pattern-driven PHY, latency and reset checks.
module tb_gige_mdio_ctrl;

  localparam int D   = 4;
  localparam int LAT = 128 * D + 1;

  logic        clk_50 = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [4:0]  req_phy, req_reg;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        mdc, mdio_o, mdio_oe, init_done;
  logic        mdio_i = 1'b1;

  int checks = 0;
  int errors = 0;

  gige_mdio_ctrl #(.MDC_DIV(D)) dut (
    .clk_50    (clk_50),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_phy   (req_phy),
    .req_reg   (req_reg),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mdc       (mdc),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .mdio_i    (mdio_i),
    .init_done (init_done)
  );

  always #5 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PHY model and frame capture, all on the falling clk edge
  logic [63:0] pat = '1;
  logic [63:0] cap = '0, oecap = '0;
  int          req_seq = 0, seen_seq = 0, fall_cnt = 64, rsp_cnt = 0, rise_tot = 0;
  logic        mdc_d = 1'b0;

  always @(negedge clk_50) begin
    if (seen_seq != req_seq) begin
      seen_seq = req_seq;
      fall_cnt = 0;
      cap      = '0;
      oecap    = '0;
    end
    if (mdc && !mdc_d) begin
      rise_tot++;
      if (fall_cnt < 64) begin
        cap[63-fall_cnt]   = mdio_o;
        oecap[63-fall_cnt] = mdio_oe;
      end
    end
    if (!mdc && mdc_d) fall_cnt++;
    mdc_d  = mdc;
    mdio_i = (fall_cnt < 64) ? pat[63-fall_cnt] : 1'b1;
    if (rsp_valid) rsp_cnt++;
  end

  task automatic drive(input logic wr, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd);
    req_write = wr;
    req_phy   = phy;
    req_reg   = rg;
    req_wdata = wd;
  endtask

  // Present a request, wait for acceptance, return cycles from accept to rsp_valid
  task automatic do_req(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                        input logic [15:0] wd, output int lat);
    int w;
    @(negedge clk_50);
    drive(wr, phy, rg, wd);
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 2000) begin
      @(negedge clk_50);
      w++;
    end
    if (w >= 2000) chk("accept_timeout", {63'd0, req_ready}, 64'd1);
    req_seq++;
    @(negedge clk_50);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < LAT + 50) begin
      @(negedge clk_50);
      lat++;
    end
  endtask

  initial begin
    int lat, rsp_before, ready_seen, w;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 16'h0);
    repeat (3) @(negedge clk_50);

    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_mdc",       {63'd0, mdc}, 64'd0);
    chk("rst_mdio_o",    {63'd0, mdio_o}, 64'd1);
    chk("rst_mdio_oe",   {63'd0, mdio_oe}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {48'd0, rsp_rdata}, 64'd0);
    chk("rst_rsp_err",   {63'd0, rsp_err}, 64'd0);
    chk("rst_init_done", {63'd0, init_done}, 64'd0);

    reset_n = 1'b1;
`ifdef GIGE_MDIO_INIT_EN
    req_valid  = 1'b1;
    rsp_before = rsp_cnt;
    rise_tot   = 0;
    ready_seen = 0;
    w = 0;
    while (!init_done && w < 6 * LAT) begin
      @(negedge clk_50);
      if (req_ready) ready_seen++;
      w++;
    end
    req_valid = 1'b0;
    chk("init_done",       {63'd0, init_done}, 64'd1);
    chk("init_mdc_rises",  64'(rise_tot), 64'd256);
    chk("init_rsp_valid",  64'(rsp_cnt - rsp_before), 64'd0);
    chk("init_ready_seen", 64'(ready_seen), 64'd0);
`else
    repeat (2) @(negedge clk_50);
    chk("init_done", {63'd0, init_done}, 64'd1);
    chk("idle_ready", {63'd0, req_ready}, 64'd1);
`endif

    // Write phy 1 reg 0 = 0x1340
    pat = '1;
    do_req(1'b1, 5'd1, 5'd0, 16'h1340, lat);
    chk("wr_latency", 64'(lat), 64'(LAT));
    chk("wr_frame",   cap, 64'hFFFF_FFFF_5082_1340);
    chk("wr_oe",      oecap, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_rdata",   {48'd0, rsp_rdata}, 64'd0);
    chk("wr_err",     {63'd0, rsp_err}, 64'd0);

    // Read phy 0 reg 2, PHY answers TA=0 and 0x0141
    pat = {32'hFFFF_FFFF, 14'h3FFF, 2'b10, 16'h0141};
    do_req(1'b0, 5'd0, 5'd2, 16'h0, lat);
    chk("rd_latency", 64'(lat), 64'(LAT));
    chk("rd_rdata",   {48'd0, rsp_rdata}, 64'h0141);
    chk("rd_err",     {63'd0, rsp_err}, 64'd0);
    chk("rd_oe",      oecap, 64'hFFFF_FFFF_FFFC_0000);
    chk("rd_cmd",     {50'd0, cap[31:18]}, 64'(14'b01_10_00000_00010));
    repeat (5) @(negedge clk_50);
    chk("rd_hold",    {48'd0, rsp_rdata}, 64'h0141);

    // Read with no PHY: line floats high
    pat = '1;
    do_req(1'b0, 5'd0, 5'd2, 16'h0, lat);
    chk("nophy_rdata", {48'd0, rsp_rdata}, 64'hFFFF);
    chk("nophy_err",   {63'd0, rsp_err}, 64'd1);

    // Back-to-back with req_valid held high
    @(negedge clk_50);
    drive(1'b1, 5'd0, 5'd9, 16'h0200);
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk_50);
      w++;
    end
    req_seq++;
    w = 0;
    do begin
      @(negedge clk_50);
      w++;
    end while (!rsp_valid && w < LAT + 50);
    chk("b2b_first_lat",  64'(w), 64'(LAT));
    chk("b2b_done_ready", {63'd0, req_ready}, 64'd0);
    drive(1'b0, 5'd3, 5'd1, 16'h0);
    @(negedge clk_50);
    chk("b2b_ready_next", {63'd0, req_ready}, 64'd1);
    chk("b2b_mdc_idle",   {63'd0, mdc}, 64'd0);
    req_seq++;
    @(negedge clk_50);
    chk("b2b_taken",      {63'd0, req_ready}, 64'd0);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < LAT + 50) begin
      @(negedge clk_50);
      lat++;
    end
    chk("b2b_second_lat", 64'(lat), 64'(LAT));
    chk("b2b_rdata",      {48'd0, rsp_rdata}, 64'hFFFF);

    // Reset in the middle of a write's DATA phase, mdc high
    @(negedge clk_50);
    drive(1'b1, 5'd1, 5'd0, 16'hAAAA);
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk_50);
      w++;
    end
    req_seq++;
    @(negedge clk_50);
    req_valid = 1'b0;
    repeat (121 * D) @(negedge clk_50);
    chk("mid_mdc_high", {63'd0, mdc}, 64'd1);
    chk("mid_oe_high",  {63'd0, mdio_oe}, 64'd1);
    rsp_before = rsp_cnt;
    #2 reset_n = 1'b0;
    #1;
    chk("abort_mdc",   {63'd0, mdc}, 64'd0);
    chk("abort_oe",    {63'd0, mdio_oe}, 64'd0);
    chk("abort_mdio",  {63'd0, mdio_o}, 64'd1);
    chk("abort_rdata", {48'd0, rsp_rdata}, 64'd0);
    chk("abort_err",   {63'd0, rsp_err}, 64'd0);
    chk("abort_ready", {63'd0, req_ready}, 64'd0);
    repeat (3) @(negedge clk_50);
    reset_n = 1'b1;
`ifdef GIGE_MDIO_INIT_EN
    w = 0;
    while (!init_done && w < 6 * LAT) begin
      @(negedge clk_50);
      w++;
    end
`else
    repeat (20 * D) @(negedge clk_50);
`endif
    chk("abort_no_rsp", 64'(rsp_cnt - rsp_before), 64'd0);

    pat = {32'hFFFF_FFFF, 14'h3FFF, 2'b10, 16'h0141};
    do_req(1'b0, 5'd0, 5'd2, 16'h0, lat);
    chk("post_rst_lat",   64'(lat), 64'(LAT));
    chk("post_rst_rdata", {48'd0, rsp_rdata}, 64'h0141);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gige_mdio_ctrl.md
GIGE_MDIO_CTRL -- requirements
Module: gige_mdio_ctrl

Interface
REQ-001 SHALL have parameter MDC_DIV, default 13, clk_50 cycles per MDC half-period (MDC ~1.92 MHz at 50 MHz).
REQ-002 SHALL have port clk_50  input  1  sole clock, 50 MHz.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  management request present.
REQ-005 SHALL have port req_ready  output  1  controller can accept a request.
REQ-006 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_phy  input  5  PHY address.
REQ-008 SHALL have port req_reg  input  5  register address.
REQ-009 SHALL have port req_wdata  input  16  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion strobe.
REQ-011 SHALL have port rsp_rdata  output  16  read data; 0 after writes.
REQ-012 SHALL have port rsp_err  output  1  read turnaround not driven low by PHY.
REQ-013 SHALL have port mdc  output  1  management clock to both PHYs.
REQ-014 SHALL have port mdio_o  output  1  MDIO drive value.
REQ-015 SHALL have port mdio_oe  output  1  MDIO output enable; 0 = tristate.
REQ-016 SHALL have port mdio_i  input  1  MDIO pin, pre-synchronised.
REQ-017 SHALL have port init_done  output  1  boot configuration complete.

Function
REQ-018 SHALL emit Clause-22 frames of 64 bits: 32 preamble ones, ST=01, OP (01 write, 10 read), PHYAD MSB first, REGAD MSB first, TA, 16 data bits MSB first.
REQ-019 SHALL make each bit period 2*MDC_DIV cycles: mdc low for the first MDC_DIV, high for the second.
REQ-020 SHALL update mdio_o/mdio_oe on the first cycle of each bit period and sample mdio_i on the cycle mdc rises.
REQ-021 SHALL use states IDLE -> PRE (32 bits) -> CMD (14 bits) -> TA (2 bits) -> DATA (16 bits) -> DONE (1 cycle) -> IDLE.
REQ-022 SHALL assert req_ready only in IDLE with init_done=1; handshake is req_valid&&req_ready; request fields are latched in that cycle.
REQ-023 SHALL begin PRE the cycle after acceptance and pulse rsp_valid in DONE, exactly 128*MDC_DIV+1 cycles after the accept cycle.
REQ-024 SHALL drive TA as 1,0 on writes; on reads release mdio_oe from TA bit 1 through the end of DATA.
REQ-025 SHALL set rsp_err=1 if mdio_i sampled in read TA bit 2 equals 1; rsp_rdata is still returned.
REQ-026 SHALL hold rsp_rdata/rsp_err stable from DONE until the next DONE.
REQ-027 SHALL hold mdc=0 and mdio_oe=0 in IDLE; req_valid without req_ready is ignored and not queued.
REQ-028 SHALL accept a new request in the cycle after DONE (no back-to-back gap beyond one IDLE cycle).

Reset
REQ-029 SHALL on reset_n=0 force immediately: state IDLE, mdc=0, mdio_o=1, mdio_oe=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-030 SHALL abort any frame in progress on reset with no rsp_valid issued for it.

Configuration
REQ-031 SHALL, with GIGE_MDIO_INIT_EN defined, reset init_done to 0 and, after reset release, issue the package init table writes in order via the same frame engine, then set init_done=1.
REQ-032 SHALL not pulse rsp_valid for init writes.
REQ-033 SHALL, without GIGE_MDIO_INIT_EN, set init_done=1 on reset release and omit the init logic entirely.

Structure
REQ-034 SHALL place in package gige_mdio_pkg: state enum, ST/OP/TA constants, INIT_LEN=4 and init table {phy 0 reg 0x09 0x0200; phy 1 reg 0x09 0x0200; phy 0 reg 0x00 0x1340; phy 1 reg 0x00 0x1340}.
REQ-035 SHALL contain one sub-module gige_mdio_tick generating the bit-start and rising-edge strobes from MDC_DIV.

Verification
REQ-036 Write phy 1 reg 0 data 0x1340 -> mdio_o serial 32x1,01,01,00001,00000,10,0001001101000000; rsp_valid at 128*MDC_DIV+1.
REQ-037 Read phy 0 reg 2, PHY model drives TA 0 and 0x0141 -> rsp_rdata=0x0141, rsp_err=0, mdio_oe=0 during TA2/DATA.
REQ-038 Read with mdio_i held 1 (no PHY) -> rsp_rdata=0xFFFF, rsp_err=1.
REQ-039 req_valid held high for two requests -> second accepted the cycle after first rsp_valid; mdc idle low between.
REQ-040 reset_n low mid-DATA -> mdio_oe=0, mdc=0 same cycle; no rsp_valid; next request completes normally.
REQ-041 With GIGE_MDIO_INIT_EN -> four init frames observed, req_ready=0 until init_done=1, no rsp_valid during init.
